// File: rtl/fifo_rd_sink_if.sv
// FIFO read-port handshake between the FIFO (master) and the frame sink (slave).
interface fifo_rd_sink_if #(
  parameter int DW = 16
);
  logic [DW-1:0] data_out;
  logic          data_out_vld;
  logic          b_rdy;

  modport master (
    output data_out,
    output data_out_vld,
    input  b_rdy
  );

  modport slave (
    input  data_out,
    input  data_out_vld,
    output b_rdy
  );
endinterface

// File: rtl/fifo_rd_sink.sv
// Frame sink: pulls FRAME_LEN words from a FIFO read port and publishes the
// frame's sum and XOR, one bubble cycle per frame, with a wrapping frame counter.
module fifo_rd_sink #(
  parameter int FRAME_LEN = 8,
  parameter int DW        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  fifo_rd_sink_if.slave    rd,
  output logic [DW+7:0]    sum,
  output logic [DW-1:0]    xsum,
  output logic             sum_vld,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

  state_t          state_q;
  logic [7:0]      cnt_q;
  logic [DW+7:0]   acc_q;
  logic [DW-1:0]   xacc_q;
  logic [DW+7:0]   sum_q;
  logic [DW-1:0]   xsum_q;
  logic            sum_vld_q;
  logic [7:0]      frame_cnt_q;

  logic [DW+7:0]   acc_d;
  logic [DW-1:0]   xacc_d;
  logic            xfer_s;
  logic            last_s;

  // Ready is combinational so a word can be taken on the very first RECV cycle.
  assign rd.b_rdy = (state_q == RECV) && en;

  // Accumulator next values including the word currently on the bus.
  always_comb begin
    xfer_s = rd.data_out_vld & rd.b_rdy;
    last_s = (cnt_q == LAST_CNT);
    acc_d  = acc_q + {8'd0, rd.data_out};
    xacc_d = xacc_q ^ rd.data_out;
  end

  // Frame FSM with its accumulators and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      acc_q       <= '0;
      xacc_q      <= '0;
      sum_q       <= '0;
      xsum_q      <= '0;
      sum_vld_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      sum_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) state_q <= RECV;
          else    state_q <= IDLE;
        end
        RECV: begin
          if (xfer_s) begin
            if (last_s) begin
              // Publish the completed frame and restart the accumulators.
              sum_q       <= acc_d;
              xsum_q      <= xacc_d;
              acc_q       <= '0;
              xacc_q      <= '0;
              cnt_q       <= 8'd0;
              sum_vld_q   <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 8'd1;
              state_q     <= DONE;
            end else begin
              acc_q  <= acc_d;
              xacc_q <= xacc_d;
              cnt_q  <= cnt_q + 8'd1;
            end
          end else begin
            state_q <= RECV;
          end
        end
        DONE: begin
          if (en) state_q <= RECV;
          else    state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sum       = sum_q;
  assign xsum      = xsum_q;
  assign sum_vld   = sum_vld_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_rd_sink.sv
// Randomised and directed bench for fifo_rd_sink against a queue-based frame model.
module tb_fifo_rd_sink;
  localparam int FL = 8;
  localparam int DW = 16;

  typedef logic [DW-1:0] frame_t [FL];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [DW+7:0] sum;
  logic [DW-1:0] xsum;
  logic          sum_vld;
  logic [7:0]    frame_cnt;

  fifo_rd_sink_if #(.DW(DW)) bus ();

  fifo_rd_sink #(.FRAME_LEN(FL), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rd        (bus.slave),
    .sum       (sum),
    .xsum      (xsum),
    .sum_vld   (sum_vld),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int dut_pulses = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Model: phase 0 = waiting for enable, 1 = collecting, 2 = bubble after a frame.
  int            m_phase = 0;
  logic [DW-1:0] m_q[$];
  logic [31:0]   m_sum  = 32'd0;
  logic [31:0]   m_xsum = 32'd0;
  bit            m_vld  = 1'b0;
  int            m_fcnt = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_q.delete(); m_sum = 32'd0; m_xsum = 32'd0; m_vld = 1'b0; m_fcnt = 0;
      end else begin
        m_vld = 1'b0;
        if (m_phase == 0) begin
          if (en) m_phase = 1;
        end else if (m_phase == 1) begin
          if (en && bus.data_out_vld) begin
            m_q.push_back(bus.data_out);
            if (m_q.size() == FL) begin
              m_sum = 32'd0; m_xsum = 32'd0;
              foreach (m_q[k]) begin
                m_sum  = m_sum + 32'(m_q[k]);
                m_xsum = m_xsum ^ 32'(m_q[k]);
              end
              m_q.delete();
              m_vld   = 1'b1;
              m_fcnt  = (m_fcnt + 1) % 256;
              m_phase = 2;
            end
          end
        end else begin
          m_phase = en ? 1 : 0;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("b_rdy",     32'(bus.b_rdy),  32'(m_phase == 1 && en));
      chk("sum",       32'(sum),        m_sum);
      chk("xsum",      32'(xsum),       m_xsum);
      chk("sum_vld",   32'(sum_vld),    32'(m_vld));
      chk("frame_cnt", 32'(frame_cnt),  32'(m_fcnt));
      if (sum_vld === 1'b1) dut_pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n words of w (from IDLE/DONE), optionally dropping en for gap_len cycles after gap_after words.
  task automatic send_frame(input frame_t w, input int n, input int gap_after, input int gap_len);
    int  i = 0;
    int  cyc = 0;
    bit  gapped = 1'b0;
    bit  take;
    en = 1'b1;
    while (i < n && cyc < 200) begin
      if (!gapped && gap_len > 0 && i == gap_after) begin
        en = 1'b0;
        gapped = 1'b1;
        for (int g = 0; g < gap_len; g++) begin
          bus.data_out = 16'($urandom);
          bus.data_out_vld = 1'b1;
          step();
          cyc++;
        end
        en = 1'b1;
      end
      bus.data_out = w[i];
      bus.data_out_vld = 1'b1;
      @(negedge clk);
      take = bus.b_rdy;
      step();
      if (take) i++;
      cyc++;
    end
    if (i < n) chk("frame_timeout", 32'(i), 32'(n));
    bus.data_out = 16'($urandom);
  endtask

  frame_t seq18, allf;

  initial begin
    bus.data_out = '0;
    bus.data_out_vld = 1'b0;
    for (int k = 0; k < FL; k++) begin
      seq18[k] = 16'(k + 1);
      allf[k]  = 16'hFFFF;
    end

    repeat (3) step();
    chk("rst_sum",   32'(sum),       32'd0);
    chk("rst_fcnt",  32'(frame_cnt), 32'd0);
    chk("rst_b_rdy", 32'(bus.b_rdy), 32'd0);
    rst_n = 1'b1;
    step();

    // Words 1..8 back to back.
    send_frame(seq18, FL, 0, 0);
    chk("t033_sum",     32'(sum),       32'd36);
    chk("t033_xsum",    32'(xsum),      32'd8);
    chk("t033_vld",     32'(sum_vld),   32'd1);
    chk("t033_fcnt",    32'(frame_cnt), 32'd1);
    chk("t033_b_rdy",   32'(bus.b_rdy), 32'd0);
    chk("t033_model",   m_sum,          32'd36);
    en = 1'b0;
    step();

    // All-ones frame must fit the widened accumulator.
    send_frame(allf, FL, 0, 0);
    chk("t034_sum",  32'(sum),       32'h07FFF8);
    chk("t034_xsum", 32'(xsum),      32'h0);
    chk("t034_fcnt", 32'(frame_cnt), 32'd2);
    en = 1'b0;
    step();

    // Enable gap of 5 cycles after word 3.
    send_frame(seq18, FL, 3, 5);
    chk("t035_sum",  32'(sum),       32'd36);
    chk("t035_fcnt", 32'(frame_cnt), 32'd3);
    en = 1'b0;
    step();

    // Valid data while idle is ignored.
    repeat (4) begin
      bus.data_out = 16'($urandom);
      bus.data_out_vld = 1'b1;
      step();
    end
    chk("t036_fcnt", 32'(frame_cnt), 32'd3);
    chk("t036_sum",  32'(sum),       32'd36);

    // Reset mid-frame after word 4.
    send_frame(seq18, 4, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t037_sum",   32'(sum),       32'd0);
    chk("t037_xsum",  32'(xsum),      32'd0);
    chk("t037_vld",   32'(sum_vld),   32'd0);
    chk("t037_fcnt",  32'(frame_cnt), 32'd0);
    chk("t037_b_rdy", 32'(bus.b_rdy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    send_frame(seq18, FL, 0, 0);
    chk("t037_sum2",  32'(sum),       32'd36);
    chk("t037_fcnt2", 32'(frame_cnt), 32'd1);
    en = 1'b0;
    step();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(7) != 0);
      bus.data_out_vld = $urandom_range(1);
      bus.data_out = 16'($urandom);
      rst_n = ($urandom_range(499) != 0);
      step();
    end
    rst_n = 1'b1;
    en = 1'b0;
    step();

    // 256 back-to-back frames from a clean reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    begin
      int base;
      base = dut_pulses;
      en = 1'b1;
      bus.data_out_vld = 1'b1;
      for (int c = 1; c <= 256 * 9; c++) begin
        bus.data_out = 16'($urandom);
        step();
        if (c == 255 * 9) chk("t038_fcnt255", 32'(frame_cnt), 32'd255);
      end
      chk("t038_fcnt_wrap", 32'(frame_cnt), 32'd0);
      chk("t038_vld",       32'(sum_vld),   32'd1);
      chk("t038_model",     32'(m_fcnt),    32'd0);
      @(negedge clk);
      #1;
      chk("t038_pulses", 32'(dut_pulses - base), 32'd256);
    end
    en = 1'b0;
    bus.data_out_vld = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/fifo_rd_sink.md
FIFO_RD_SINK -- requirements
Module: fifo_rd_sink

Interface
REQ-001 Parameter FRAME_LEN, default 8: words per frame, legal range 2..255.
REQ-002 Parameter DW, default 16: data word width, matches the FIFO read port.
REQ-003 clk  input  1  single clock, read-side domain of the FIFO; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  consume enable from control logic.
REQ-006 data_out  input  DW  read data from the FIFO.
REQ-007 data_out_vld  input  1  high when data_out holds a valid word.
REQ-008 b_rdy  output  1  ready to the FIFO; the sink accepts a word this cycle.
REQ-009 sum  output  DW+8  sum of the last completed frame.
REQ-010 xsum  output  DW  bitwise XOR of the last completed frame.
REQ-011 sum_vld  output  1  one-cycle pulse; sum and xsum are fresh.
REQ-012 frame_cnt  output  8  count of completed frames.

Function
REQ-013 A transfer SHALL occur at a rising edge only when data_out_vld=1 and b_rdy=1; data_out_vld while b_rdy=0 SHALL be ignored with no state change.
REQ-014 The FSM SHALL have three states: IDLE, RECV and DONE.
REQ-015 Transition IDLE->RECV SHALL happen on the first edge with en=1.
REQ-016 Transition RECV->DONE SHALL happen on the transfer of word FRAME_LEN.
REQ-017 Transition DONE->RECV (en=1) or DONE->IDLE (en=0) SHALL happen after exactly one cycle.
REQ-018 b_rdy SHALL equal (state==RECV) AND en, combinationally: low in IDLE and DONE, low while en=0 in RECV.
REQ-019 en=0 in RECV SHALL pause the frame; word count and accumulators SHALL be held, and reception resumes when en returns to 1.
REQ-020 On each transfer, the accumulator SHALL add data_out, zero-extended to DW+8 bits.
REQ-021 On each transfer, the XOR accumulator SHALL XOR data_out.
REQ-022 On each transfer, the word counter (8 bits) SHALL increment.
REQ-023 On the last transfer of a frame, sum and xsum SHALL register the final values, including that last word.
REQ-024 On the same last transfer, the accumulators and word counter SHALL clear to 0.
REQ-025 sum_vld SHALL be 1 for exactly the one cycle spent in DONE, i.e. one cycle after the last transfer.
REQ-026 sum and xsum SHALL hold their value until the next frame completes.
REQ-027 frame_cnt SHALL increment on the same edge that sets sum_vld.
REQ-028 frame_cnt SHALL wrap from 255 to 0.
REQ-029 The accumulator width DW+8 SHALL never overflow for FRAME_LEN<=255.
REQ-030 Max throughput SHALL be one word per cycle inside a frame, plus one bubble cycle (DONE) per frame.

Reset
REQ-031 With rst_n=0, regardless of clk: state=IDLE, b_rdy=0, sum=0, xsum=0, sum_vld=0, frame_cnt=0, and word counter and accumulators = 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; after release, the next frame starts from word 1.

Verification
REQ-033 FRAME_LEN=8, en=1, data_out_vld=1 with words 1..8 on consecutive cycles: sum=36, xsum=8, sum_vld one cycle after word 8, frame_cnt=1, b_rdy=0 in that cycle.
REQ-034 Eight words of 0xFFFF: sum=0x07FFF8, xsum=0x0000, no overflow.
REQ-035 en dropped for 5 cycles after word 3 of 1..8: b_rdy=0 during the gap, words held off are not counted, final sum=36 when the frame completes.
REQ-036 data_out_vld=1 during IDLE and DONE: no count change, results unaffected.
REQ-037 rst_n pulsed low after word 4: all outputs 0 immediately; the following 8-word frame 1..8 yields sum=36 and frame_cnt=1.
REQ-038 256 back-to-back frames: frame_cnt wraps to 0, each frame shows exactly one sum_vld pulse and one bubble cycle.
